// File: rtl/boot_loader_if.sv
// Byte-stream input and memory debug-write bundle for boot_loader.
//   rx_data/rx_valid : byte source -> loader
//   rx_ready         : loader -> byte source
//   debug/waddr_cpu/data_cpu : loader -> memory debug write port
// master: loader side; slave: byte source / memory side.
interface boot_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        debug;
  logic [31:0] waddr_cpu;
  logic [31:0] data_cpu;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, debug, waddr_cpu, data_cpu
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, debug, waddr_cpu, data_cpu
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: assembles a framed byte stream (4-byte LSB-first word count,
// N LSB-first data words, 8-bit data-only checksum) into 32-bit words,
// writes them through the memory debug port and holds the CPU in reset
// until a verified image is present.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : single-cycle load request
//   bus        : byte stream in, debug write port out (boot_loader_if.master)
//   cpu_hold   : CPU pipeline reset, low only once a verified image is loaded
//   done, err  : load verified / load aborted
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 65536
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  boot_loader_if.master bus,
  output logic          cpu_hold,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt;
  logic [31:0] count_q;
  logic [16:0] idx_q;
  logic [7:0]  sum_q;
  logic [31:0] word_q;
  logic        armed_q;

  logic        accept;
  logic        last_byte;
  logic [31:0] len_full;
  logic [31:0] word_full;
  logic        len_bad;
  logic        last_idx;

  assign bus.rx_ready = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign bus.debug    = (state_q == S_WRITE);
  assign cpu_hold     = (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);

  assign accept    = bus.rx_valid && bus.rx_ready;
  assign last_byte = (byte_cnt == 2'd3);
  // Bytes arrive LSB first, so each new byte enters at the top and shifts down.
  assign len_full  = {bus.rx_data, count_q[31:8]};
  assign word_full = {bus.rx_data, word_q[31:8]};
  assign len_bad   = (len_full == '0) || (len_full > 32'(MAX_WORDS));
  assign last_idx  = ({15'b0, idx_q} == (count_q - 32'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // armed_q masks a start coinciding with reset release.
      S_IDLE:  if (start && armed_q) state_d = S_LEN;
      S_LEN:   if (accept && last_byte) state_d = len_bad ? S_ERR : S_DATA;
      S_DATA:  if (accept && last_byte) state_d = S_WRITE;
      S_WRITE: state_d = last_idx ? S_CSUM : S_DATA;
      S_CSUM:  if (accept) state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERR;
      S_DONE:  if (start) state_d = S_LEN;
      S_ERR:   if (start) state_d = S_LEN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt      <= '0;
      count_q       <= '0;
      idx_q         <= '0;
      sum_q         <= '0;
      word_q        <= '0;
      armed_q       <= 1'b0;
      bus.waddr_cpu <= '0;
      bus.data_cpu  <= '0;
    end else begin
      armed_q <= 1'b1;
      unique case (state_q)
        S_LEN: begin
          if (accept) begin
            count_q  <= len_full;
            byte_cnt <= byte_cnt + 2'd1;
            if (last_byte) begin
              idx_q <= '0;
              sum_q <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            word_q   <= word_full;
            sum_q    <= sum_q + bus.rx_data;
            byte_cnt <= byte_cnt + 2'd1;
            // Write port registers load on the edge entering WRITE.
            if (last_byte) begin
              bus.waddr_cpu <= BASE_ADDR + {15'b0, idx_q};
              bus.data_cpu  <= word_full;
            end
          end
        end
        S_WRITE: idx_q <= idx_q + 17'd1;
        default: byte_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic cpu_hold, done, err;

  boot_loader_if bif ();

  boot_loader #(.BASE_ADDR(32'h100)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bus      (bif.master),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words[$];
  logic [63:0] exp_e;
  logic        dbg_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every debug cycle pops one expected (addr,data) pair.
  always @(negedge clk) begin
    if (bif.debug === 1'b1) begin
      chk("debug_single_cycle", {31'b0, dbg_prev}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        chk("waddr_cpu", bif.waddr_cpu, exp_e[63:32]);
        chk("data_cpu", bif.data_cpu, exp_e[31:0]);
      end
    end
    dbg_prev = bif.debug;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit got = 0;
    bif.rx_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bif.rx_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    chk("byte_accept", {31'b0, got}, 32'd1);
    if (got) begin
      @(posedge clk);
      #1;
    end
    bif.rx_valid = 1'b0;
  endtask

  task automatic send_count(input logic [31:0] c, input int gap);
    for (int i = 0; i < 4; i++) send_byte(c[8*i +: 8], gap);
  endtask

  // Sends words[] as a frame; checksum is the data-byte sum plus csum_add.
  task automatic send_frame(input logic [7:0] csum_add, input int gap);
    logic [7:0]  s = '0;
    logic [31:0] w;
    send_count(32'(words.size()), gap);
    for (int k = 0; k < words.size(); k++) begin
      w = words[k];
      exp_q.push_back({32'h100 + 32'(k), w});
      for (int i = 0; i < 4; i++) begin
        s = s + w[8*i +: 8];
        send_byte(w[8*i +: 8], gap);
      end
    end
    send_byte(s + csum_add, gap);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_ready"}, {31'b0, bif.rx_ready}, 32'd0);
    chk({tag, "_debug"}, {31'b0, bif.debug}, 32'd0);
    chk({tag, "_waddr"}, bif.waddr_cpu, 32'd0);
    chk({tag, "_data"}, bif.data_cpu, 32'd0);
    chk({tag, "_cpu_hold"}, {31'b0, cpu_hold}, 32'd1);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_err"}, {31'b0, err}, 32'd0);
  endtask

  initial begin
    start        = 1'b0;
    bif.rx_data  = 8'h00;
    bif.rx_valid = 1'b0;
    rst_n        = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("reset");

    // start coinciding with reset release must be ignored
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_at_release_ignored", {31'b0, bif.rx_ready}, 32'd0);
    chk("idle_cpu_hold", {31'b0, cpu_hold}, 32'd1);

    // nominal two-word load
    words = '{32'h12345678, 32'hDEADBEEF};
    do_start();
    chk("len_rx_ready", {31'b0, bif.rx_ready}, 32'd1);
    send_frame(8'h00, 0);
    chk("nominal_done", {31'b0, done}, 32'd1);
    chk("nominal_cpu_hold", {31'b0, cpu_hold}, 32'd0);
    chk("nominal_err", {31'b0, err}, 32'd0);
    chk("nominal_rx_ready", {31'b0, bif.rx_ready}, 32'd0);
    chk("nominal_writes_seen", 32'(exp_q.size()), 32'd0);

    // reload from DONE overwrites the same addresses
    do_start();
    chk("reload_done_clear", {31'b0, done}, 32'd0);
    chk("reload_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    words = '{32'hAABBCCDD, 32'h01020304};
    send_frame(8'h00, 0);
    chk("reload_done", {31'b0, done}, 32'd1);
    chk("reload_writes_seen", 32'(exp_q.size()), 32'd0);

    // bad checksum: words still written, err raised
    do_start();
    words = '{32'h12345678, 32'hDEADBEEF};
    send_frame(8'h01, 0);
    chk("badsum_err", {31'b0, err}, 32'd1);
    chk("badsum_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    chk("badsum_done", {31'b0, done}, 32'd0);
    chk("badsum_writes_seen", 32'(exp_q.size()), 32'd0);

    // zero length
    do_start();
    chk("restart_err_clear", {31'b0, err}, 32'd0);
    send_count(32'd0, 0);
    chk("zero_len_err", {31'b0, err}, 32'd1);
    chk("zero_len_rx_ready", {31'b0, bif.rx_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1 chk("zero_len_err_held", {31'b0, err}, 32'd1);

    // oversize counts, compared at full width
    do_start();
    send_count(32'h0001_0001, 0);
    chk("len_65537_err", {31'b0, err}, 32'd1);
    do_start();
    send_count(32'h0100_0000, 0);
    chk("len_high_byte_err", {31'b0, err}, 32'd1);

    // back-pressure: 3 idle cycles before every byte
    do_start();
    words = '{32'hCAFEF00D};
    send_frame(8'h00, 3);
    chk("stall_done", {31'b0, done}, 32'd1);
    chk("stall_err", {31'b0, err}, 32'd0);
    chk("stall_writes_seen", 32'(exp_q.size()), 32'd0);

    // reset after two data bytes, then a clean reload
    do_start();
    send_count(32'd1, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_start();
    words = '{32'h87654321};
    send_frame(8'h00, 0);
    chk("post_reset_done", {31'b0, done}, 32'd1);
    chk("post_reset_cpu_hold", {31'b0, cpu_hold}, 32'd0);
    chk("post_reset_writes_seen", 32'(exp_q.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
